// File: rtl/cv_psg_if.sv
// Z80-side write port of the sound generator: write strobe, data byte, READY.
interface cv_psg_if;
  logic       we_n_i;
  logic [7:0] data_i;
  logic       ready_o;

  // CPU / address-decoder side
  modport master (output we_n_i, output data_i, input ready_o);
  // Sound generator side
  modport slave (input we_n_i, input data_i, output ready_o);
endinterface

// File: rtl/cv_psg.sv
// SN76489AN-compatible sound generator: three 10-bit tone channels, one
// 15-bit LFSR noise channel, 4-bit attenuation per channel, 6-bit linear mix.
// All sound logic advances only on the 3.58 MHz clock enable.
module cv_psg (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_3m58_p_i,
  cv_psg_if.slave    bus,
  output logic [5:0] aud_o
);

  logic        ready;
  logic [4:0]  busy_cnt;
  logic [3:0]  presc;
  logic        tick16;
  logic [2:0]  index;
  logic [2:0]  noise_ctrl;
  logic [2:0]  tone_out;
  logic [6:0]  noise_cnt;
  logic [6:0]  noise_reload;
  logic        noise_tog;
  logic        noise_prev;
  logic        noise_src;
  logic        noise_fb;
  logic [14:0] lfsr;
  logic        wr_acc;
  logic        noise_wr;
  logic [2:0]  wr_idx;
  logic [3:0]  chan_bit;
  logic [3:0]  lvl [4];
  logic [5:0]  mix;

  assign bus.ready_o = ready;
  assign wr_acc      = ~bus.we_n_i & ready;
  // Latch bytes carry their own index; data bytes reuse the latched one
  assign wr_idx      = bus.data_i[7] ? bus.data_i[6:4] : index;
  assign noise_wr    = wr_acc & (wr_idx == 3'd6);
  assign tick16      = clk_en_3m58_p_i & (presc == 4'hF);
  assign chan_bit    = {lfsr[0], tone_out};

  // Write handshake: drop READY on acceptance, raise it on the 32nd enable after
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready    <= 1'b1;
      busy_cnt <= '0;
    end else if (wr_acc) begin
      ready    <= 1'b0;
      busy_cnt <= '0;
    end else if (!ready && clk_en_3m58_p_i) begin
      busy_cnt <= busy_cnt + 5'd1;
      if (busy_cnt == 5'd31) ready <= 1'b1;
    end
  end

  // Latched register index and noise control
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      index      <= '0;
      noise_ctrl <= '0;
    end else if (wr_acc) begin
      if (bus.data_i[7]) index <= bus.data_i[6:4];
      if (wr_idx == 3'd6) noise_ctrl <= bus.data_i[2:0];
    end
  end

  // Divide the enable by 16 to get the channel tick
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) presc <= '0;
    else if (clk_en_3m58_p_i) presc <= presc + 4'd1;
  end

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_tone
    logic [9:0] period;
    logic [9:0] cnt;
    logic       out;

    // Tone period register: latch byte sets the low nibble, data byte the high six bits
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        period <= '0;
      end else if (wr_acc && (wr_idx == 3'(2 * gi))) begin
        if (bus.data_i[7]) period[3:0] <= bus.data_i[3:0];
        else               period[9:4] <= bus.data_i[5:0];
      end
    end

    // Down-counter reloads only when it expires, so a new period lands at the next reload;
    // a period of 0 or 1 toggles on every tick
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt <= '0;
        out <= 1'b0;
      end else if (tick16) begin
        if (cnt <= 10'd1) begin
          cnt <= period;
          out <= ~out;
        end else begin
          cnt <= cnt - 10'd1;
        end
      end
    end

    assign tone_out[gi] = out;
  end

  for (gi = 0; gi < 4; gi++) begin : g_att
    logic [3:0] att;

    // Attenuation register for channel gi (odd register indices)
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) att <= 4'hF;
      else if (wr_acc && (wr_idx == 3'(2 * gi + 1))) att <= bus.data_i[3:0];
    end

    assign lvl[gi] = chan_bit[gi] ? (4'hF - att) : 4'h0;
  end

  // Internal noise rate select; the NF=11 setting ignores this counter
  always_comb begin
    noise_reload = 7'd64;
    case (noise_ctrl[1:0])
      2'b00:   noise_reload = 7'd16;
      2'b01:   noise_reload = 7'd32;
      default: noise_reload = 7'd64;
    endcase
  end

  // Internal noise clock divider, same expire-and-reload rule as a tone channel
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      noise_cnt <= '0;
      noise_tog <= 1'b0;
    end else if (tick16) begin
      if (noise_cnt <= 7'd1) begin
        noise_cnt <= noise_reload;
        noise_tog <= ~noise_tog;
      end else begin
        noise_cnt <= noise_cnt - 7'd1;
      end
    end
  end

  assign noise_src = (noise_ctrl[1:0] == 2'b11) ? tone_out[2] : noise_tog;
  assign noise_fb  = noise_ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];

  // LFSR shifts on each rising noise clock; a noise register write reseeds and wins
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      noise_prev <= 1'b0;
      lfsr       <= 15'h4000;
    end else begin
      noise_prev <= noise_src;
      if (noise_wr) lfsr <= 15'h4000;
      else if (noise_src && !noise_prev) lfsr <= {noise_fb, lfsr[14:1]};
    end
  end

  // Sum of the four channel levels (max 4 x 15 = 60)
  always_comb begin
    mix = '0;
    for (int i = 0; i < 4; i++) mix = mix + {2'b00, lvl[i]};
  end

  // Registered audio sample
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) aud_o <= '0;
    else            aud_o <= mix;
  end

endmodule

// File: tb/tb_cv_psg.sv
// Self-checking bench for cv_psg: table-driven write vectors, directed
// multi-cycle sequences and randomized writes against a behavioural model.
module tb_cv_psg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [5:0] aud;

  cv_psg_if bus_if ();

  cv_psg dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .clk_en_3m58_p_i (en),
    .bus             (bus_if),
    .aud_o           (aud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  int n_fail_lines;

  // Behavioural model state (plain integers)
  int m_tone [3];
  int m_cnt  [3];
  int m_out  [3];
  int m_att  [4];
  int m_nctrl, m_ncnt, m_ntog, m_nprev, m_lfsr, m_index;
  int m_presc, m_busy, m_ready, m_aud, m_shifts, m_en_count;

  typedef struct {
    logic [7:0] data;
    int         exp_ready_next;
    int         exp_busy;
  } wr_vec_t;

  wr_vec_t tone_tab  [3];
  wr_vec_t noise_tab [3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      if (n_fail_lines < 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      n_fail_lines++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tone[i] = 0; m_cnt[i] = 0; m_out[i] = 0;
    end
    for (int i = 0; i < 4; i++) m_att[i] = 15;
    m_nctrl = 0; m_ncnt = 0; m_ntog = 0; m_nprev = 0;
    m_lfsr = 'h4000; m_index = 0; m_presc = 0; m_busy = 0;
    m_ready = 1; m_aud = 0;
  endtask

  // One clock edge of the reference behaviour; uses only the bench's own stimulus
  task automatic model_update();
    int sum, nclk, fb, b, idx, period;
    bit tick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sum = 0;
    for (int i = 0; i < 3; i++) sum += (m_out[i] != 0) ? 15 - m_att[i] : 0;
    sum += ((m_lfsr & 1) != 0) ? 15 - m_att[3] : 0;
    nclk = ((m_nctrl % 4) == 3) ? m_out[2] : m_ntog;
    if (nclk != 0 && m_nprev == 0) begin
      fb = (((m_nctrl >> 2) & 1) != 0) ? ((m_lfsr ^ (m_lfsr >> 1)) & 1) : (m_lfsr & 1);
      m_lfsr = (m_lfsr >> 1) | (fb << 14);
      m_shifts++;
    end
    m_nprev = nclk;
    tick = 1'b0;
    if (en) begin
      m_en_count++;
      tick = (m_presc == 15);
      m_presc = (m_presc + 1) % 16;
    end
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] <= 1) begin m_cnt[i] = m_tone[i]; m_out[i] = 1 - m_out[i]; end
        else m_cnt[i] = m_cnt[i] - 1;
      end
      period = ((m_nctrl % 4) == 0) ? 16 : ((m_nctrl % 4) == 1) ? 32 : 64;
      if (m_ncnt <= 1) begin m_ncnt = period; m_ntog = 1 - m_ntog; end
      else m_ncnt = m_ncnt - 1;
    end
    if (!bus_if.we_n_i && m_ready != 0) begin
      b = int'(bus_if.data_i);
      idx = (b >= 128) ? ((b >> 4) & 7) : m_index;
      if (b >= 128) m_index = idx;
      if (idx == 6) begin
        m_nctrl = b & 7;
        m_lfsr = 'h4000;
      end else if ((idx % 2) == 1) m_att[idx / 2] = b & 15;
      else if (b >= 128) m_tone[idx / 2] = (m_tone[idx / 2] & 'h3F0) | (b & 15);
      else m_tone[idx / 2] = (m_tone[idx / 2] & 'hF) | ((b & 'h3F) << 4);
      m_ready = 0;
      m_busy = 0;
    end else if (m_ready == 0 && en) begin
      m_busy++;
      if (m_busy == 32) m_ready = 1;
    end
    m_aud = sum;
  endtask

  // Advance one clock, compare outputs on the falling edge, then drive the next enable
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("aud_o", int'(aud), m_aud);
    chk("ready_o", int'(bus_if.ready_o), m_ready);
    en = ~en;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    int acc;
    acc = m_ready;
    bus_if.we_n_i = 1'b0;
    bus_if.data_i = b;
    step();
    bus_if.we_n_i = 1'b1;
    $display("write 0x%02h %s (aud_o=%0d)", b, (acc != 0) ? "accepted" : "ignored", aud);
  endtask

  task automatic wait_ready(output int n);
    int e0, k;
    e0 = m_en_count;
    k = 0;
    while (bus_if.ready_o !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    if (bus_if.ready_o !== 1'b1) chk("ready_timeout", 0, 1);
    n = m_en_count - e0;
  endtask

  task automatic wait_aud_change(input int limit);
    int last, k;
    last = int'(aud);
    k = 0;
    while (int'(aud) == last && k < limit) begin
      step();
      k++;
    end
    if (int'(aud) == last) chk("aud_change_timeout", 0, 1);
  endtask

  task automatic wait_aud_rise(input int limit);
    int k;
    k = 0;
    while (int'(aud) != 0 && k < limit) begin step(); k++; end
    while (int'(aud) == 0 && k < limit) begin step(); k++; end
    if (int'(aud) == 0) chk("aud_rise_timeout", 0, 1);
  endtask

  // Output bit of a white-noise LFSR seeded 0x4000 after k+1 shifts
  function automatic int ref_white_bit(input int k);
    int l, fb;
    l = 'h4000;
    for (int j = 0; j <= k; j++) begin
      fb = (l ^ (l >> 1)) & 1;
      l = (l >> 1) | (fb << 14);
    end
    return l & 1;
  endfunction

  task automatic run_table(input wr_vec_t v, output int shifts_at_wr);
    int n;
    wr_byte(v.data);
    shifts_at_wr = m_shifts;
    chk($sformatf("ready_low_after_0x%02h", v.data), int'(bus_if.ready_o), v.exp_ready_next);
    wait_ready(n);
    chk($sformatf("busy_enables_0x%02h", v.data), n, v.exp_busy);
  endtask

  initial begin
    int n, e0, base, k, sh;

    tone_tab[0]  = '{8'h8E, 0, 32};
    tone_tab[1]  = '{8'h0F, 0, 32};
    tone_tab[2]  = '{8'h90, 0, 32};
    noise_tab[0] = '{8'h9F, 0, 32};
    noise_tab[1] = '{8'hF0, 0, 32};
    noise_tab[2] = '{8'hE4, 0, 32};

    n_checks = 0; n_pass = 0; n_fail_lines = 0;
    m_shifts = 0; m_en_count = 0;
    rst_n = 1'b0; en = 1'b0;
    bus_if.we_n_i = 1'b1;
    bus_if.data_i = 8'h00;
    model_reset();
    repeat (3) step();
    chk("reset_aud", int'(aud), 0);
    chk("reset_ready", int'(bus_if.ready_o), 1);
    rst_n = 1'b1;

    // 1000 enables of silence
    repeat (2000) step();
    chk("idle_aud", int'(aud), 0);

    // Tone0 = 0x0FE, att0 = 0
    for (int i = 0; i < 3; i++) run_table(tone_tab[i], sh);
    wait_aud_change(10000);
    wait_aud_change(10000);
    e0 = m_en_count;
    wait_aud_change(10000);
    chk("tone0_half_period_enables", m_en_count - e0, 254 * 16);
    chk("tone0_level_0_or_15", int'(aud == 6'd0 || aud == 6'd15), 1);

    // A write during the busy window is ignored
    wr_byte(8'h90);
    repeat (4) step();
    chk("busy_ready_low", int'(bus_if.ready_o), 0);
    wr_byte(8'h9F);
    wait_ready(n);
    k = 0;
    while (aud == 6'd0 && k < 10000) begin step(); k++; end
    chk("ch0_still_level15", int'(aud), 15);

    // White noise, NF=00, on channel 3 only
    base = 0;
    for (int i = 0; i < 3; i++) begin
      run_table(noise_tab[i], sh);
      if (noise_tab[i].data == 8'hE4) base = sh;
    end
    for (int j = 0; j < 16; j++) begin
      k = 0;
      while (m_shifts < base + j + 1 && k < 1200) begin step(); k++; end
      if (m_shifts < base + j + 1) chk("lfsr_shift_timeout", 0, 1);
      step();
      chk($sformatf("white_lfsr_bit%0d", j), int'(aud), 15 * ref_white_bit(j));
    end

    // Periodic noise clocked by tone2 = 1: one pulse per 15 shifts of 32 enables
    wr_byte(8'hC1); wait_ready(n);
    wr_byte(8'hE3); wait_ready(n);
    wait_aud_rise(3000);
    e0 = m_en_count;
    wait_aud_rise(3000);
    chk("periodic_pulse_spacing", m_en_count - e0, 15 * 32);
    chk("periodic_pulse_level", int'(aud), 15);

    // Full-scale mix after a fresh reset keeps all channels in phase
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    wr_byte(8'h90); wait_ready(n);
    wr_byte(8'hB0); wait_ready(n);
    wr_byte(8'hD0); wait_ready(n);
    wr_byte(8'hF0); wait_ready(n);
    wr_byte(8'hE3); wait_ready(n);
    k = 0;
    while (aud != 6'd60 && k < 6000) begin step(); k++; end
    chk("max_mix_60", int'(aud), 60);

    // Asynchronous reset during the busy window
    wr_byte(8'h91);
    k = 0;
    while (aud == 6'd0 && k < 40) begin step(); k++; end
    chk("pre_reset_busy", int'(bus_if.ready_o), 0);
    chk("pre_reset_aud_nonzero", int'(aud != 6'd0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ready", int'(bus_if.ready_o), 1);
    chk("async_reset_aud", int'(aud), 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;

    // Randomized writes, some landing in the busy window
    for (int i = 0; i < 60; i++) begin
      wr_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 90)) step();
    end
    repeat (200) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
